// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a byte-wide register file plus a read-only status byte.
// All pins are oversampled on clk; edges come from the synchronized copies.
module spi_reg_responder #(
   parameter int unsigned ADDR_W      = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 ss,
   input  logic                                 sck,
   input  logic                                 mosi,
   output logic                                 miso,
   input  logic [7:0]                           status_in,
   output logic [8*((1 << ADDR_W) - 1) - 1:0]   reg_out,
   output logic                                 wr_strobe,
   output logic [ADDR_W-1:0]                    wr_addr,
   output logic [7:0]                           wr_data
);

   localparam int unsigned NREGS = 1 << ADDR_W;
   localparam int unsigned RW    = 8 * (NREGS - 1);
   localparam int unsigned CNT_W = 3;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMD  = 2'd1,
      S_DATA = 2'd2
   } state_t;

   // Readback mux: writable registers, status byte at the top address.
   function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a,
                                          input logic [RW-1:0]     regs,
                                          input logic [7:0]        st);
      logic [7:0] v;
      v = st;
      for (int unsigned k = 0; k < NREGS - 1; k++) begin
         if (a == ADDR_W'(k)) v = regs[8*k +: 8];
      end
      return v;
   endfunction

   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic [SYNC_STAGES-1:0] r_sck_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic                   r_ss_d;
   logic                   r_sck_d;

   state_t                 r_state,   w_state_nxt;
   logic [CNT_W-1:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]             r_rx,      w_rx_nxt;
   logic [7:0]             r_tx,      w_tx_nxt;
   logic [ADDR_W-1:0]      r_addr,    w_addr_nxt;
   logic                   r_rw,      w_rw_nxt;
   logic [RW-1:0]          r_reg_out, w_regs_nxt;
   logic [ADDR_W-1:0]      r_wr_addr, w_wr_addr_nxt;
   logic [7:0]             r_wr_data, w_wr_data_nxt;
   logic                   r_pend,    w_pend_nxt;
   logic                   r_wr_strobe;
   logic                   r_miso,    w_miso_nxt;

   logic                   w_ss;
   logic                   w_sck;
   logic                   w_mosi;
   logic                   w_sel_rise;
   logic                   w_sck_rise;
   logic                   w_sck_fall;
   logic [7:0]             w_rx_byte;
   logic [ADDR_W-1:0]      w_addr_inc;

   assign w_ss       = r_ss_sync[SYNC_STAGES-1];
   assign w_sck      = r_sck_sync[SYNC_STAGES-1];
   assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
   assign w_sel_rise = w_ss & ~r_ss_d;
   assign w_sck_rise = w_sck & ~r_sck_d;
   assign w_sck_fall = ~w_sck & r_sck_d;
   assign w_rx_byte  = {r_rx[6:0], w_mosi};
   assign w_addr_inc = r_addr + ADDR_W'(1);

   // Select chain resets high so a select held through reset never looks like a new frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ss_sync   <= '1;
         r_sck_sync  <= '0;
         r_mosi_sync <= '0;
         r_ss_d      <= 1'b1;
         r_sck_d     <= 1'b0;
      end else begin
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss};
         r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
         r_ss_d      <= w_ss;
         r_sck_d     <= w_sck;
      end
   end

   // Frame state register and all datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_bit_cnt   <= '0;
         r_rx        <= '0;
         r_tx        <= '0;
         r_addr      <= '0;
         r_rw        <= 1'b0;
         r_reg_out   <= '0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_pend      <= 1'b0;
         r_wr_strobe <= 1'b0;
         r_miso      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_rx        <= w_rx_nxt;
         r_tx        <= w_tx_nxt;
         r_addr      <= w_addr_nxt;
         r_rw        <= w_rw_nxt;
         r_reg_out   <= w_regs_nxt;
         r_wr_addr   <= w_wr_addr_nxt;
         r_wr_data   <= w_wr_data_nxt;
         r_pend      <= w_pend_nxt;
         r_wr_strobe <= r_pend;
         r_miso      <= w_miso_nxt;
      end
   end

   // Next-state and datapath update.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_rx_nxt      = r_rx;
      w_tx_nxt      = r_tx;
      w_addr_nxt    = r_addr;
      w_rw_nxt      = r_rw;
      w_regs_nxt    = r_reg_out;
      w_wr_addr_nxt = r_wr_addr;
      w_wr_data_nxt = r_wr_data;
      w_pend_nxt    = 1'b0;

      if (!w_ss) begin
         w_state_nxt   = S_IDLE;
         w_bit_cnt_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_sel_rise) begin
                  w_state_nxt   = S_CMD;
                  w_bit_cnt_nxt = '0;
                  w_rx_nxt      = '0;
               end
            end
            S_CMD: begin
               if (w_sck_rise) begin
                  w_rx_nxt = w_rx_byte;
                  if (r_bit_cnt == CNT_W'(7)) begin
                     w_rw_nxt      = w_rx_byte[7];
                     w_addr_nxt    = w_rx_byte[ADDR_W-1:0];
                     w_bit_cnt_nxt = '0;
                     w_state_nxt   = S_DATA;
                     if (!w_rx_byte[7]) begin
                        w_tx_nxt = rd_byte(w_rx_byte[ADDR_W-1:0], r_reg_out, status_in);
                     end
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            S_DATA: begin
               // First fall after a (re)load keeps bit 7 on the line.
               if (!r_rw && w_sck_fall && (r_bit_cnt != '0)) begin
                  w_tx_nxt = {r_tx[6:0], 1'b0};
               end
               if (w_sck_rise) begin
                  w_rx_nxt = w_rx_byte;
                  if (r_bit_cnt == CNT_W'(7)) begin
                     w_bit_cnt_nxt = '0;
                     w_addr_nxt    = w_addr_inc;
                     if (!r_rw) begin
                        w_tx_nxt = rd_byte(w_addr_inc, r_reg_out, status_in);
                     end else if (r_addr != ADDR_W'(NREGS - 1)) begin
                        for (int unsigned k = 0; k < NREGS - 1; k++) begin
                           if (r_addr == ADDR_W'(k)) w_regs_nxt[8*k +: 8] = w_rx_byte;
                        end
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = w_rx_byte;
                        w_pend_nxt    = 1'b1;
                     end
                  end else begin
                     w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end

      w_miso_nxt = ((w_state_nxt == S_DATA) && !w_rw_nxt) ? w_tx_nxt[7] : 1'b0;
   end

   assign miso      = r_miso;
   assign reg_out   = r_reg_out;
   assign wr_strobe = r_wr_strobe;
   assign wr_addr   = r_wr_addr;
   assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_spi_reg_responder.sv
// Directed bench for spi_reg_responder: a bit-banged mode-0 master drives frames and
// immediate assertions compare outputs against hand-computed values.
module tb_spi_reg_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        ss;
   logic        sck;
   logic        mosi;
   logic        miso;
   logic [7:0]  status_in;
   logic [23:0] reg_out;
   logic        wr_strobe;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          ph     = 6;
   int          n_strobe = 0;
   logic [1:0]  last_addr = 2'd0;
   logic [7:0]  last_data = 8'd0;
   logic        miso_seen = 1'b0;
   logic [7:0]  tx_buf [8];
   logic [7:0]  rx_buf [8];
   logic [7:0]  r_tmp;

   spi_reg_responder #(.ADDR_W(2), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .ss        (ss),
      .sck       (sck),
      .mosi      (mosi),
      .miso      (miso),
      .status_in (status_in),
      .reg_out   (reg_out),
      .wr_strobe (wr_strobe),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (wr_strobe) begin
         n_strobe  = n_strobe + 1;
         last_addr = wr_addr;
         last_data = wr_data;
      end
      if (miso) miso_seen = 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic half();
      #(ph * 10);
   endtask

   task automatic spi_bit(input logic b, output logic r);
      mosi = b;
      half();
      sck = 1'b1;
      r   = miso;
      half();
      sck = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
      for (int i = 7; i >= 0; i--) spi_bit(b[i], r[i]);
   endtask

   task automatic clear_mon();
      n_strobe  = 0;
      miso_seen = 1'b0;
   endtask

   task automatic do_frame(input int n);
      ss = 1'b1;
      half();
      for (int k = 0; k < n; k++) spi_byte(tx_buf[k], rx_buf[k]);
      half();
      ss = 1'b0;
      #120;
   endtask

   task automatic set_tx(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input logic [7:0] b5);
      tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2;
      tx_buf[3] = b3; tx_buf[4] = b4; tx_buf[5] = b5;
   endtask

   task automatic read_burst_checks(input string pfx);
      clear_mon();
      set_tx(8'h80, 8'h5A, 8'hC3, 8'h0F, 8'h00, 8'h00);
      do_frame(4);
      chk({pfx, "_preload_regs"}, 32'(reg_out), 32'h0F_C3_5A);
      chk({pfx, "_preload_strobes"}, 32'(n_strobe), 32'd3);
      chk({pfx, "_preload_last_addr"}, 32'(last_addr), 32'd2);
      clear_mon();
      set_tx(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
      do_frame(6);
      chk({pfx, "_rd_cmd_phase"}, 32'(rx_buf[0]), 32'h00);
      chk({pfx, "_rd_b0"}, 32'(rx_buf[1]), 32'h5A);
      chk({pfx, "_rd_b1"}, 32'(rx_buf[2]), 32'hC3);
      chk({pfx, "_rd_b2"}, 32'(rx_buf[3]), 32'h0F);
      chk({pfx, "_rd_status"}, 32'(rx_buf[4]), 32'h96);
      chk({pfx, "_rd_wrap"}, 32'(rx_buf[5]), 32'h5A);
      chk({pfx, "_rd_no_strobe"}, 32'(n_strobe), 32'd0);
      chk({pfx, "_rd_regs_kept"}, 32'(reg_out), 32'h0F_C3_5A);
   endtask

   initial begin
      rst = 1'b1; ss = 1'b0; sck = 1'b0; mosi = 1'b0; status_in = 8'h96;
      #22;
      chk("reset_miso", 32'(miso), 32'd0);
      chk("reset_reg_out", 32'(reg_out), 32'd0);
      chk("reset_strobe", 32'(wr_strobe), 32'd0);
      chk("reset_wr_addr", 32'(wr_addr), 32'd0);
      chk("reset_wr_data", 32'(wr_data), 32'd0);
      #20 rst = 1'b0;
      #40;

      // Single write to reg1.
      clear_mon();
      set_tx(8'h81, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
      do_frame(2);
      chk("wr1_reg_out", 32'(reg_out), 32'h00_A5_00);
      chk("wr1_strobes", 32'(n_strobe), 32'd1);
      chk("wr1_addr", 32'(last_addr), 32'd1);
      chk("wr1_data", 32'(last_data), 32'hA5);
      chk("wr1_miso_quiet", 32'(miso_seen), 32'd0);

      // Burst wrapping over the status address.
      clear_mon();
      set_tx(8'h82, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00);
      do_frame(4);
      chk("burst_reg_out", 32'(reg_out), 32'h11_A5_33);
      chk("burst_strobes", 32'(n_strobe), 32'd2);
      chk("burst_last_addr", 32'(last_addr), 32'd0);
      chk("burst_last_data", 32'(last_data), 32'h33);
      chk("burst_wr_addr_held", 32'(wr_addr), 32'd0);
      chk("burst_wr_data_held", 32'(wr_data), 32'h33);
      chk("burst_miso_quiet", 32'(miso_seen), 32'd0);

      read_burst_checks("slow");

      // Write command then half a data byte, then deselect.
      clear_mon();
      ss = 1'b1;
      half();
      spi_byte(8'h80, r_tmp);
      for (int i = 0; i < 4; i++) spi_bit(1'b1, r_tmp[i]);
      half();
      ss = 1'b0;
      #120;
      chk("abort_regs", 32'(reg_out), 32'h0F_C3_5A);
      chk("abort_strobes", 32'(n_strobe), 32'd0);
      chk("abort_miso", 32'(miso), 32'd0);

      // Read of reg1 (bit7 set) aborted while miso is high.
      ss = 1'b1;
      half();
      spi_byte(8'h01, r_tmp);
      half();
      chk("rdabort_miso_driven", 32'(miso), 32'd1);
      ss = 1'b0;
      #40;
      chk("rdabort_miso_low", 32'(miso), 32'd0);
      #80;

      // Upper command bits are ignored.
      clear_mon();
      set_tx(8'hFD, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
      do_frame(2);
      chk("cmdbits_reg_out", 32'(reg_out), 32'h0F_44_5A);
      chk("cmdbits_strobes", 32'(n_strobe), 32'd1);
      chk("cmdbits_addr", 32'(last_addr), 32'd1);

      // Reset mid-write-frame, select held through reset.
      clear_mon();
      ss = 1'b1;
      half();
      spi_byte(8'h80, r_tmp);
      for (int i = 0; i < 3; i++) spi_bit(1'b0, r_tmp[i]);
      rst = 1'b1;
      #1;
      chk("midrst_miso", 32'(miso), 32'd0);
      chk("midrst_reg_out", 32'(reg_out), 32'd0);
      chk("midrst_strobe", 32'(wr_strobe), 32'd0);
      #29 rst = 1'b0;
      half();
      spi_byte(8'h80, r_tmp);
      spi_byte(8'h77, r_tmp);
      half();
      ss = 1'b0;
      #120;
      chk("midrst_no_frame_reg", 32'(reg_out), 32'd0);
      chk("midrst_no_frame_strobe", 32'(n_strobe), 32'd0);
      set_tx(8'h80, 8'h77, 8'h00, 8'h00, 8'h00, 8'h00);
      do_frame(2);
      chk("midrst_reselect_reg", 32'(reg_out), 32'h00_00_77);
      chk("midrst_reselect_strobe", 32'(n_strobe), 32'd1);

      // Minimum sck phase at a random offset from clk.
      ph = 4;
      @(posedge clk);
      #($urandom_range(1, 9));
      clear_mon();
      set_tx(8'h81, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00);
      do_frame(2);
      chk("fast_wr_reg_out", 32'(reg_out), 32'h00_A5_77);
      chk("fast_wr_strobes", 32'(n_strobe), 32'd1);
      chk("fast_wr_data", 32'(last_data), 32'hA5);
      read_burst_checks("fast");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
